// File: rtl/synth_pkg.sv
// ============================================================================
// Module  : synth_pkg
// Purpose : Shared widths, voice count and period type for the synth blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package synth_pkg;
  localparam int NUM_VOICES = 4;
  localparam int PERIOD_W   = 32;
  localparam int SAMPLE_W   = 8;

  typedef logic [PERIOD_W-1:0] period_t;

  localparam period_t SILENT_PERIOD = '0;
endpackage

`default_nettype wire

// File: rtl/square_voice.sv
// ============================================================================
// Module  : square_voice
// Purpose : One 50%-duty square oscillator: period counter, wrap, level reg.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module square_voice
  import synth_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  period_t period_i,
  output logic    voice_hi_o
);

  period_t cnt_q;
  period_t cnt_d;
  logic    hi_q;
  logic    hi_d;
  logic    active;

  // Wrap on >= so a period that shrinks below the count recovers next clock.
  always_comb begin
    active = (period_i >= period_t'(2));
    cnt_d  = cnt_q + period_t'(1);
    if (!active) begin
      cnt_d = SILENT_PERIOD;
    end else if (cnt_q >= (period_i - period_t'(1))) begin
      cnt_d = '0;
    end
    hi_d = active && (cnt_q < (period_i >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign voice_hi_o = hi_q;

endmodule

`default_nettype wire

// File: rtl/square_voice_mixer.sv
// ============================================================================
// Module  : square_voice_mixer
// Purpose : Four square voices summed to an 8-bit sample, optional PWM output
//           (enabled by SQUARE_VOICE_MIXER_PWM_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module square_voice_mixer
  import synth_pkg::*;
#(
  parameter int AMP = 63
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PERIOD_W-1:0]   period0,
  input  logic [PERIOD_W-1:0]   period1,
  input  logic [PERIOD_W-1:0]   period2,
  input  logic [PERIOD_W-1:0]   period3,
  output logic [SAMPLE_W-1:0]   sample,
  output logic [NUM_VOICES-1:0] voice_hi,
  output logic                  pwm_out
);

  localparam int SUM_W = 10;

  period_t             periods [NUM_VOICES];
  logic [SUM_W-1:0]    sum_d;
  logic [SAMPLE_W-1:0] sample_d;
  logic [SAMPLE_W-1:0] sample_q;

  assign periods[0] = period0;
  assign periods[1] = period1;
  assign periods[2] = period2;
  assign periods[3] = period3;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    square_voice u_voice (
      .clk        (clk),
      .rst        (rst),
      .period_i   (periods[gi]),
      .voice_hi_o (voice_hi[gi])
    );
  end

  // Clamp never fires while 4*AMP <= 255; it only keeps the top bits honest.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_hi[i]) begin
        sum_d = sum_d + SUM_W'(AMP);
      end
    end
    sample_d = (sum_d > SUM_W'(255)) ? {SAMPLE_W{1'b1}} : sum_d[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

`ifdef SQUARE_VOICE_MIXER_PWM_EN
  logic [SAMPLE_W-1:0] pwm_cnt_q;
  logic [SAMPLE_W-1:0] duty_q;
  logic                pwm_q;

  // Duty reloads only at the frame boundary so each frame is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + SAMPLE_W'(1);
      if (pwm_cnt_q == {SAMPLE_W{1'b1}}) begin
        duty_q <= sample_q;
      end
      pwm_q <= (pwm_cnt_q < duty_q);
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_square_voice_mixer.sv
// ============================================================================
// Module  : tb_square_voice_mixer
// Purpose : Self-checking bench for square_voice_mixer (closed-form reference).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_square_voice_mixer;
  localparam int AMP = 63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic [7:0]  sample;
  logic [3:0]  voice_hi;
  logic        pwm_out;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;   // rising edges since reset release

  typedef struct { logic [3:0] vh; logic [7:0] smp; } exp_t;
  exp_t sb [$];

  typedef struct {
    logic [31:0] a, b, c, d;
    int          cycles;
    logic [7:0]  peak;
  } vec_t;
  vec_t tbl [8];

  square_voice_mixer #(.AMP(AMP)) dut (
    .clk      (clk),
    .rst      (rst),
    .period0  (p0),
    .period1  (p1),
    .period2  (p2),
    .period3  (p3),
    .sample   (sample),
    .voice_hi (voice_hi),
    .pwm_out  (pwm_out)
  );

  always #5 clk = ~clk;

  // Level after kk edges from a phase-aligned start: counter value (kk-1) mod P.
  function automatic logic ehi(input logic [31:0] p, input int kk);
    if (kk <= 0 || p < 32'd2) return 1'b0;
    return ((32'(kk - 1) % p) < (p >> 1));
  endfunction

  function automatic logic [3:0] evh(input int kk);
    return {ehi(p3, kk), ehi(p2, kk), ehi(p1, kk), ehi(p0, kk)};
  endfunction

  function automatic logic [7:0] esmp(input int kk);
    logic [3:0] v;
    logic [7:0] s;
    v = evh(kk - 1);
    s = '0;
    for (int i = 0; i < 4; i++) if (v[i]) s = s + 8'(AMP);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic start(input logic [31:0] a, b, c, d);
    rst = 1'b1;
    @(posedge clk);
    #1;
    p0 = a; p1 = b; p2 = c; p3 = d;
    rst = 1'b0;
    k = 0;
    sb.delete();
  endtask

  task automatic run_sb(input int n, output logic [7:0] peak);
    exp_t e;
    peak = '0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{evh(k + 1), esmp(k + 1)});
      step();
      e = sb.pop_front();
      check("voice_hi", 32'(voice_hi), 32'(e.vh));
      check("sample", 32'(sample), 32'(e.smp));
      if (sample > peak) peak = sample;
    end
  endtask

  initial begin
    logic [7:0]  pk;
    logic [11:0] pat;
    int          h1, h2;

    tbl[0] = '{32'd8, 32'd0, 32'd0, 32'd0, 40, 8'd63};
    tbl[1] = '{32'd7, 32'd0, 32'd0, 32'd0, 40, 8'd63};
    tbl[2] = '{32'd8, 32'd8, 32'd8, 32'd8, 40, 8'd252};
    tbl[3] = '{32'd8, 32'd8, 32'd1, 32'd8, 40, 8'd189};
    tbl[4] = '{32'd5, 32'd7, 32'd9, 32'd11, 60, 8'd252};
    tbl[5] = '{32'd3, 32'd0, 32'd0, 32'd0, 20, 8'd63};
    tbl[6] = '{32'd2, 32'd2, 32'd0, 32'd0, 20, 8'd126};
    tbl[7] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 20, 8'd63};

    #2;
    check("reset sample", 32'(sample), 32'd0);
    check("reset voice_hi", 32'(voice_hi), 32'd0);
    check("reset pwm_out", 32'(pwm_out), 32'd0);

    foreach (tbl[t]) begin
      start(tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].d);
      run_sb(tbl[t].cycles, pk);
      check($sformatf("peak vec%0d", t), 32'(pk), 32'(tbl[t].peak));
    end

    // Shrinking the period below the live count forces an immediate wrap.
    start(32'd20, 32'd0, 32'd0, 32'd0);
    repeat (10) step();
    check("pchg pre voice_hi0", 32'(voice_hi[0]), 32'd1);
    p0 = 32'd6;
    pat = 12'b001110001110;   // LSB first: edges 11..22
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("pchg voice_hi0 e%0d", k), 32'(voice_hi[0]), 32'(pat[i]));
    end

    // Asynchronous reset in mid-waveform, then phase-aligned restart.
    start(32'd8, 32'd6, 32'd10, 32'd12);
    run_sb(13, pk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst sample", 32'(sample), 32'd0);
    check("async rst voice_hi", 32'(voice_hi), 32'd0);
    check("async rst pwm_out", 32'(pwm_out), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("held rst sample", 32'(sample), 32'd0);
    check("held rst voice_hi", 32'(voice_hi), 32'd0);
    rst = 1'b0;
    k = 0;
    run_sb(30, pk);
    check("restart peak", 32'(pk), 32'd252);

    // PWM: voice 0 held high so sample sits at AMP.
    start(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    h1 = 0;
    h2 = 0;
    for (int i = 1; i <= 512; i++) begin
      step();
      if (i <= 256) h1 += int'(pwm_out);
      else          h2 += int'(pwm_out);
    end
    check("pwm held sample", 32'(sample), 32'd63);
    check("pwm frame1 highs", 32'(h1), 32'd0);
`ifdef SQUARE_VOICE_MIXER_PWM_EN
    check("pwm frame2 highs", 32'(h2), 32'd63);
`else
    check("pwm frame2 highs", 32'(h2), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
